// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// master: the program builder. slave: the encoder.
interface instr_encoder_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           fmt;
  logic [6:0]           opcode;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [31:0]          imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instruction;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instruction, out_err, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instruction, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 captures fields and checks
// that the immediate fits its format, stage 2 packs the instruction word
// (or NOP_WORD on error). Valid/ready on both sides; full-rate streaming.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  enc_if
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Stage 1 registers
  logic                 s1_v_q, s1_v_d;
  logic [2:0]           s1_fmt_q;
  logic [6:0]           s1_opcode_q;
  logic [4:0]           s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [2:0]           s1_funct3_q;
  logic [6:0]           s1_funct7_q;
  logic [31:0]          s1_imm_q;
  logic                 s1_err_q, s1_err_d;

  // Stage 2 registers
  logic                 s2_v_q, s2_v_d;
  logic [31:0]          instr_q, instr_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 load_s1;
  logic signed [31:0]   imm_s;
  logic [31:0]          word;

  assign s2_adv  = !s2_v_q || enc_if.out_ready;
  assign s1_adv  = !s1_v_q || s2_adv;
  assign load_s1 = s1_adv && enc_if.in_valid;
  assign imm_s   = signed'(enc_if.imm);

  // Immediate range/alignment check on the incoming request
  always_comb begin
    s1_err_d = 1'b0;
    case (enc_if.fmt)
      FMT_R:        s1_err_d = 1'b0;
      FMT_I, FMT_S: s1_err_d = (imm_s < -2048) || (imm_s > 2047);
      FMT_B:        s1_err_d = (imm_s < -4096) || (imm_s > 4094) || enc_if.imm[0];
      FMT_J:        s1_err_d = (imm_s < -1048576) || (imm_s > 1048574) || enc_if.imm[0];
      FMT_U:        s1_err_d = (enc_if.imm[11:0] != 12'd0);
      default:      s1_err_d = 1'b1;
    endcase
  end

  // Stage 1 occupancy: refills whenever it is empty or stage 2 takes its entry
  always_comb begin
    s1_v_d = s1_v_q;
    if (s1_adv) s1_v_d = enc_if.in_valid;
  end

  // Stage 1 capture of request fields and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_fmt_q    <= '0;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
      s1_err_q    <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (load_s1) begin
        s1_fmt_q    <= enc_if.fmt;
        s1_opcode_q <= enc_if.opcode;
        s1_rd_q     <= enc_if.rd;
        s1_rs1_q    <= enc_if.rs1;
        s1_rs2_q    <= enc_if.rs2;
        s1_funct3_q <= enc_if.funct3;
        s1_funct7_q <= enc_if.funct7;
        s1_imm_q    <= enc_if.imm;
        s1_err_q    <= s1_err_d;
      end
    end
  end

  // Field packing for the stage-1 entry; unused fields stay zero
  always_comb begin
    word = '0;
    case (s1_fmt_q)
      FMT_R: word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_I: word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      FMT_S: word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                     s1_imm_q[4:0], s1_opcode_q};
      FMT_B: word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                     s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      FMT_U: word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      FMT_J: word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                     s1_rd_q, s1_opcode_q};
      default: word = '0;
    endcase
  end

  // Stage 2 next state; output word/flag only change when stage 2 advances,
  // which keeps them stable under backpressure
  always_comb begin
    s2_v_d  = s2_v_q;
    instr_d = instr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        instr_d = s1_err_q ? NOP_WORD : word;
        err_d   = s1_err_q;
      end
    end
    if (s2_v_q && enc_if.out_ready && err_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Stage 2 output registers and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q  <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s2_v_q  <= s2_v_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign enc_if.in_ready    = s1_adv;
  assign enc_if.out_valid   = s2_v_q;
  assign enc_if.instruction = instr_q;
  assign enc_if.out_err     = err_q;
  assign enc_if.err_count   = cnt_q;

endmodule
